// File: rtl/temp_meas_seq.sv
// Conversion sequencer for the PTAT/CTAT ramp-and-compare temperature front end.
// Drives the 1V8 analog controls, counts each ramp until the comparator trips and hands both counts out over valid/ready.
module temp_meas_seq #(
    parameter int CNT_W      = 8,
    parameter int SETTLE_CYC = 16,
    parameter int PERIOD_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_req,
    input  logic                cont_en,
    input  logic [PERIOD_W-1:0] period_cyc,
    input  logic                CMPO_1V8,
    output logic                PWRUP_1V8,
    output logic                PTAT_1V8,
    output logic                CTAT_1V8,
    output logic                RESET_1V8,
    output logic                busy,
    output logic [CNT_W-1:0]    ptat_cnt,
    output logic [CNT_W-1:0]    ctat_cnt,
    output logic [1:0]          timeout,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [2:0]          state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PWRUP  = 3'd1;
    localparam logic [2:0] S_RST_P  = 3'd2;
    localparam logic [2:0] S_RAMP_P = 3'd3;
    localparam logic [2:0] S_RST_C  = 3'd4;
    localparam logic [2:0] S_RAMP_C = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_WAIT   = 3'd7;

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

    logic [2:0]          state_q;
    logic [2:0]          state_next;
    logic                cmpo_meta;
    logic                cmpo_sync;
    logic [SET_W-1:0]    settle_cnt;
    logic [CNT_W-1:0]    ramp_cnt;
    logic [PERIOD_W-1:0] wait_cnt;
    logic                ramp_end;

    logic pwrup_d;
    logic ptat_d;
    logic ctat_d;
    logic rst_d;
    logic busy_d;
    logic valid_d;

    assign state    = state_q;
    // A ramp ends on the first synchronised trip, or when the counter saturates.
    assign ramp_end = cmpo_sync || (ramp_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            PWRUP_1V8 <= 1'b0;
            PTAT_1V8  <= 1'b0;
            CTAT_1V8  <= 1'b0;
            RESET_1V8 <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            state_q   <= state_next;
            PWRUP_1V8 <= pwrup_d;
            PTAT_1V8  <= ptat_d;
            CTAT_1V8  <= ctat_d;
            RESET_1V8 <= rst_d;
            busy      <= busy_d;
            res_valid <= valid_d;
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            S_IDLE:   if (start_req) state_next = S_PWRUP;
            S_PWRUP:  if (settle_cnt == SETTLE_LAST) state_next = S_RST_P;
            S_RST_P:  state_next = S_RAMP_P;
            S_RAMP_P: if (ramp_end) state_next = S_RST_C;
            S_RST_C:  state_next = S_RAMP_C;
            S_RAMP_C: if (ramp_end) state_next = S_DONE;
            S_DONE:   if (res_ready) state_next = cont_en ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (!cont_en) begin
                    state_next = S_IDLE;
                end else if (wait_cnt <= PERIOD_W'(1)) begin
                    state_next = S_PWRUP;
                end
            end
            default:  state_next = S_IDLE;
        endcase
    end

    // Controls are decoded from the next state so they switch on the entering edge.
    always_comb begin
        pwrup_d = 1'b0;
        ptat_d  = 1'b0;
        ctat_d  = 1'b0;
        rst_d   = 1'b0;
        busy_d  = (state_next != S_IDLE);
        valid_d = (state_next == S_DONE);
        case (state_next)
            S_PWRUP:  pwrup_d = 1'b1;
            S_RST_P: begin
                pwrup_d = 1'b1;
                ptat_d  = 1'b1;
                rst_d   = 1'b1;
            end
            S_RAMP_P: begin
                pwrup_d = 1'b1;
                ptat_d  = 1'b1;
            end
            S_RST_C: begin
                pwrup_d = 1'b1;
                ctat_d  = 1'b1;
                rst_d   = 1'b1;
            end
            S_RAMP_C: begin
                pwrup_d = 1'b1;
                ctat_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmpo_meta  <= 1'b0;
            cmpo_sync  <= 1'b0;
            settle_cnt <= '0;
            ramp_cnt   <= '0;
            wait_cnt   <= '0;
            ptat_cnt   <= '0;
            ctat_cnt   <= '0;
            timeout    <= 2'b00;
        end else begin
            cmpo_meta <= CMPO_1V8;
            cmpo_sync <= cmpo_meta;

            if (state_q == S_PWRUP) begin
                settle_cnt <= settle_cnt + 1'b1;
            end else begin
                settle_cnt <= '0;
            end

            if ((state_q == S_RAMP_P) || (state_q == S_RAMP_C)) begin
                ramp_cnt <= ramp_cnt + 1'b1;
            end else begin
                ramp_cnt <= '0;
            end

            // The period is latched once on WAIT entry; later changes are ignored.
            if ((state_next == S_WAIT) && (state_q != S_WAIT)) begin
                wait_cnt <= period_cyc;
            end else if ((state_q == S_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end

            if ((state_next == S_PWRUP) && (state_q != S_PWRUP)) begin
                timeout <= 2'b00;
            end

            if (state_q == S_RAMP_P) begin
                if (cmpo_sync) begin
                    ptat_cnt <= ramp_cnt;
                end else if (ramp_end) begin
                    ptat_cnt   <= {CNT_W{1'b1}};
                    timeout[0] <= 1'b1;
                end
            end

            if (state_q == S_RAMP_C) begin
                if (cmpo_sync) begin
                    ctat_cnt <= ramp_cnt;
                end else if (ramp_end) begin
                    ctat_cnt   <= {CNT_W{1'b1}};
                    timeout[1] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_temp_meas_seq.sv
// Directed bench for temp_meas_seq: a stimulus process queues expected results,
// a monitor pops and compares them on every accepted result handshake.
module tb_temp_meas_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_req;
    logic        cont_en;
    logic [15:0] period_cyc;
    logic        CMPO_1V8;
    logic        PWRUP_1V8;
    logic        PTAT_1V8;
    logic        CTAT_1V8;
    logic        RESET_1V8;
    logic        busy;
    logic [7:0]  ptat_cnt;
    logic [7:0]  ctat_cnt;
    logic [1:0]  timeout;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;
    int excl_seen = 0;
    logic [17:0] sb_q[$];

    always #5 clk = ~clk;

    temp_meas_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start_req  (start_req),
        .cont_en    (cont_en),
        .period_cyc (period_cyc),
        .CMPO_1V8   (CMPO_1V8),
        .PWRUP_1V8  (PWRUP_1V8),
        .PTAT_1V8   (PTAT_1V8),
        .CTAT_1V8   (CTAT_1V8),
        .RESET_1V8  (RESET_1V8),
        .busy       (busy),
        .ptat_cnt   (ptat_cnt),
        .ctat_cnt   (ctat_cnt),
        .timeout    (timeout),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .state      (state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: compare each accepted result with the oldest queued expectation.
    always @(negedge clk) begin
        #2;
        if (PTAT_1V8 && CTAT_1V8) excl_seen++;
        if (res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                logic [17:0] e;
                e = sb_q.pop_front();
                check("ptat_cnt", 32'(ptat_cnt), 32'(e[17:10]));
                check("ctat_cnt", 32'(ctat_cnt), 32'(e[9:2]));
                check("timeout",  32'(timeout),  32'(e[1:0]));
            end
        end
    end

    task automatic wait_state(input logic [2:0] s);
        int n;
        n = 0;
        while (state != s && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (state != s) check("wait_state_timeout", 32'(state), 32'(s));
    endtask

    task automatic measure(input logic [2:0] s, output int len);
        wait_state(s);
        len = 0;
        while (state == s && len < 2000) begin
            len++;
            @(negedge clk);
        end
    endtask

    // Pulse CMPO so the synchronised comparator is high when the ramp counter equals n (n >= 2).
    task automatic ramp_trip(input logic [2:0] s, input int n);
        wait_state(s);
        repeat (n - 2) @(negedge clk);
        CMPO_1V8 = 1'b1;
        @(negedge clk);
        CMPO_1V8 = 1'b0;
    endtask

    task automatic pulse_start();
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check(name, {27'd0, state, PWRUP_1V8, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int n;
        reset      = 1'b1;
        start_req  = 1'b0;
        cont_en    = 1'b0;
        period_cyc = 16'd0;
        CMPO_1V8   = 1'b0;
        res_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {13'd0, PWRUP_1V8, PTAT_1V8, CTAT_1V8, RESET_1V8, busy,
                                res_valid, state, ptat_cnt, ctat_cnt, timeout} , 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // T1: trips at 100 / 60, immediate accept
        sb_q.push_back({8'd100, 8'd60, 2'b00});
        pulse_start();
        measure(3'd1, len);
        check("t1_pwrup_len", 32'(len), 32'd16);
        check("t1_rst_p_ctrl", {28'd0, state == 3'd2, PWRUP_1V8, PTAT_1V8, RESET_1V8}, 32'hF);
        ramp_trip(3'd3, 100);
        ramp_trip(3'd5, 60);
        wait_state(3'd6);
        check("t1_done_ctrl", {29'd0, res_valid, PWRUP_1V8, busy}, 32'd5);
        @(negedge clk);
        check_idle("t1_idle_after_accept");
        check("t1_valid_dropped", 32'(res_valid), 32'd0);

        // T2: comparator never trips
        sb_q.push_back({8'd255, 8'd255, 2'b11});
        pulse_start();
        measure(3'd3, len);
        check("t2_ramp_p_len", 32'(len), 32'd256);
        measure(3'd5, len);
        check("t2_ramp_c_len", 32'(len), 32'd256);
        wait_state(3'd6);
        @(negedge clk);
        check_idle("t2_idle");

        // T3: consumer stalls 20 cycles in DONE
        sb_q.push_back({8'd20, 8'd30, 2'b00});
        res_ready = 1'b0;
        pulse_start();
        ramp_trip(3'd3, 20);
        ramp_trip(3'd5, 30);
        wait_state(3'd6);
        for (int i = 0; i < 20; i++) begin
            check("t3_stall_hold", {13'd0, res_valid, state, ptat_cnt, ctat_cnt, timeout},
                  {13'd0, 1'b1, 3'd6, 8'd20, 8'd30, 2'b00});
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check_idle("t3_idle_after_accept");
        check("t3_results_persist", {16'd0, ptat_cnt, ctat_cnt}, {16'd0, 8'd20, 8'd30});

        // T4: continuous mode with period 50
        sb_q.push_back({8'd40, 8'd50, 2'b00});
        sb_q.push_back({8'd70, 8'd80, 2'b00});
        cont_en    = 1'b1;
        period_cyc = 16'd50;
        pulse_start();
        ramp_trip(3'd3, 40);
        ramp_trip(3'd5, 50);
        wait_state(3'd6);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (state != 3'd1 && n < 200);
        check("t4_restart_delay", 32'(n), 32'd51);
        ramp_trip(3'd3, 70);
        ramp_trip(3'd5, 80);
        wait_state(3'd7);
        check("t4_wait_busy", {30'd0, busy, PWRUP_1V8}, 32'd2);
        cont_en = 1'b0;
        @(negedge clk);
        check_idle("t4_cont_off_idle");

        // T5: reset in the middle of RAMP_C aborts the conversion
        pulse_start();
        ramp_trip(3'd3, 10);
        wait_state(3'd5);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_reset_outputs", {13'd0, PWRUP_1V8, PTAT_1V8, CTAT_1V8, RESET_1V8, busy,
                                   res_valid, state, ptat_cnt, ctat_cnt, timeout}, 32'd0);
        sb_q.push_back({8'd15, 8'd25, 2'b00});
        pulse_start();
        ramp_trip(3'd3, 15);
        ramp_trip(3'd5, 25);
        wait_state(3'd6);
        @(negedge clk);
        check_idle("t5_idle");

        // T6: comparator already high at ramp start; start_req during RAMP_P ignored
        sb_q.push_back({8'd0, 8'd30, 2'b00});
        CMPO_1V8 = 1'b1;
        pulse_start();
        wait_state(3'd2);
        CMPO_1V8 = 1'b0;
        @(negedge clk);
        check("t6_in_ramp_p", 32'(state), 32'd3);
        pulse_start();
        ramp_trip(3'd5, 30);
        wait_state(3'd6);
        @(negedge clk);
        check_idle("t6_idle");
        repeat (30) @(negedge clk);
        check_idle("t6_no_second_conv");

        check("queue_drained", 32'(sb_q.size()), 32'd0);
        check("ptat_ctat_exclusive", 32'(excl_seen), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
